// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the single-bus datapath controller: opcodes, ALU ops,
// FSM state encoding and the opcode decode helpers.
package cpu_ctrl_pkg;

    localparam int unsigned OPC_W = 5;
    localparam int unsigned REG_W = 4;
    localparam int unsigned NREGS = 16;
    localparam int unsigned ALU_W = 5;

    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_SHRA = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_ROR  = 5'b01010;
    localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01011;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_ANDI = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_ORI  = 5'b01110;
    localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

    localparam logic [ALU_W-1:0] ALU_NONE = 5'b00000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 5'b00001;
    localparam logic [ALU_W-1:0] ALU_SUB  = 5'b00010;
    localparam logic [ALU_W-1:0] ALU_AND  = 5'b00011;
    localparam logic [ALU_W-1:0] ALU_OR   = 5'b00100;
    localparam logic [ALU_W-1:0] ALU_SHR  = 5'b00101;
    localparam logic [ALU_W-1:0] ALU_MUL  = 5'b00110;
    localparam logic [ALU_W-1:0] ALU_DIV  = 5'b00111;
    localparam logic [ALU_W-1:0] ALU_SHRA = 5'b01000;
    localparam logic [ALU_W-1:0] ALU_SHL  = 5'b01001;
    localparam logic [ALU_W-1:0] ALU_ROR  = 5'b01010;
    localparam logic [ALU_W-1:0] ALU_ROL  = 5'b01011;
    localparam logic [ALU_W-1:0] ALU_NEG  = 5'b01100;
    localparam logic [ALU_W-1:0] ALU_NOT  = 5'b01101;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE, CLS_IMM, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } cls_e;

    // Instruction family selects the T3..T6 micro-sequence.
    function automatic cls_e op_class(input logic [OPC_W-1:0] opc);
        case (opc) inside
            [OPC_ADD:OPC_ROL]:  return CLS_RTYPE;
            [OPC_ADDI:OPC_ORI]: return CLS_IMM;
            OPC_MUL, OPC_DIV:   return CLS_MULDIV;
            OPC_NEG, OPC_NOT:   return CLS_UNARY;
            OPC_NOP:            return CLS_NOP;
            OPC_HALT:           return CLS_HALT;
            default:            return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [ALU_W-1:0] alu_op(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_ADD, OPC_ADDI: return ALU_ADD;
            OPC_SUB:           return ALU_SUB;
            OPC_AND, OPC_ANDI: return ALU_AND;
            OPC_OR, OPC_ORI:   return ALU_OR;
            OPC_SHR:           return ALU_SHR;
            OPC_SHRA:          return ALU_SHRA;
            OPC_SHL:           return ALU_SHL;
            OPC_ROR:           return ALU_ROR;
            OPC_ROL:           return ALU_ROL;
            OPC_MUL:           return ALU_MUL;
            OPC_DIV:           return ALU_DIV;
            OPC_NEG:           return ALU_NEG;
            OPC_NOT:           return ALU_NOT;
            default:           return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register field to one-hot select, gated by an enable.
module reg_select_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] sel,
    input  logic             en,
    output logic [NREGS-1:0] onehot_c
);

    always_comb begin
        onehot_c = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            onehot_c[i] = en && (sel == REG_W'(i));
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hard-wired fetch/decode/execute sequencer for the single-bus datapath.
// Moore machine: every control output decodes from the state and IR.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Start,
    input  logic [31:0]      IR,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             PCin,
    output logic             IRin,
    output logic             HIin,
    output logic             LOin,
    output logic             ZHighin,
    output logic             ZLowin,
    output logic             MARin,
    output logic             MDRin,
    output logic             Yin,
    output logic             PCout,
    output logic             HIout,
    output logic             LOout,
    output logic             ZHighout,
    output logic             ZLowout,
    output logic             MDRout,
    output logic             Cout,
    output logic             Read,
    output logic             IncPC,
    output logic [ALU_W-1:0] OP,
    output logic             Running,
    output logic             Halted,
    output logic             IllegalOp
);

    state_e           state_q;
    state_e           state_d;
    cls_e             cls;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [REG_W-1:0] rout_sel;
    logic             rout_en;
    logic             rin_en;
    logic             unused_ir;

    assign cls       = op_class(IR[31:27]);
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    always_ff @(posedge Clock) begin
        if (Clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        PCin      = 1'b0;
        IRin      = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        ZHighin   = 1'b0;
        ZLowin    = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        Yin       = 1'b0;
        PCout     = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        ZHighout  = 1'b0;
        ZLowout   = 1'b0;
        MDRout    = 1'b0;
        Cout      = 1'b0;
        Read      = 1'b0;
        IncPC     = 1'b0;
        OP        = ALU_NONE;
        IllegalOp = 1'b0;
        rout_en   = 1'b0;
        rout_sel  = rb;
        rin_en    = 1'b0;
        Running   = (state_q != S_IDLE) && (state_q != S_HALT);
        Halted    = (state_q == S_HALT);

        case (state_q)
            S_IDLE: if (Start) state_d = S_T0;
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            // Dispatch on the freshly loaded opcode.
            S_T3: begin
                state_d = S_T4;
                case (cls)
                    CLS_RTYPE, CLS_IMM: begin
                        rout_en = 1'b1;
                        Yin     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        Yin      = 1'b1;
                    end
                    CLS_UNARY: begin
                        rout_en = 1'b1;
                        ZLowin  = 1'b1;
                        OP      = alu_op(IR[31:27]);
                    end
                    CLS_NOP:  state_d = S_T0;
                    CLS_HALT: state_d = S_HALT;
                    default: begin
                        IllegalOp = 1'b1;
                        state_d   = S_T0;
                    end
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (cls)
                    CLS_RTYPE: begin
                        rout_en  = 1'b1;
                        rout_sel = rc;
                        ZLowin   = 1'b1;
                        OP       = alu_op(IR[31:27]);
                    end
                    CLS_IMM: begin
                        Cout   = 1'b1;
                        ZLowin = 1'b1;
                        OP     = alu_op(IR[31:27]);
                    end
                    CLS_MULDIV: begin
                        rout_en = 1'b1;
                        ZHighin = 1'b1;
                        ZLowin  = 1'b1;
                        OP      = alu_op(IR[31:27]);
                    end
                    CLS_UNARY: begin
                        ZLowout = 1'b1;
                        rin_en  = 1'b1;
                        state_d = S_T0;
                    end
                    default: state_d = S_T0;
                endcase
            end
            S_T5: begin
                state_d = S_T0;
                case (cls)
                    CLS_RTYPE, CLS_IMM: begin
                        ZLowout = 1'b1;
                        rin_en  = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ZLowout = 1'b1;
                        LOin    = 1'b1;
                        state_d = S_T6;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
                state_d  = S_T0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    reg_select_decoder u_rin_dec (
        .sel      (ra),
        .en       (rin_en),
        .onehot_c (Rin)
    );

    reg_select_decoder u_rout_dec (
        .sel      (rout_sel),
        .en       (rout_en),
        .onehot_c (Rout)
    );

endmodule

// File: doc/control_unit.md
# control_unit

Hard-wired sequencing controller for the single-bus datapath. It replaces the hand-driven control waveforms used in the per-instruction datapath benches. After `Start`, it repeatedly fetches an instruction, decodes `IR`, and drives every datapath enable, bus-select and ALU-op signal, one state per clock. It sits beside the datapath: it consumes `IR` and drives all datapath control inputs.

## Interface
- No parameters. Opcodes, ALU op codes and state encodings are package constants.
- `Clock` in 1: single clock, rising edge.
- `Clear` in 1: synchronous, active-high reset.
- `Start` in 1: leaves IDLE when sampled high. Ignored in every other state.
- `IR` in 32: datapath instruction register. Fields: op=`IR[31:27]`, Ra=`IR[26:23]`, Rb=`IR[22:19]`, Rc=`IR[18:15]`.
- `Rin` out 16: one-hot register write enables, bit n = Rn.
- `Rout` out 16: one-hot register bus drive, bit n = Rn.
- `PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, Yin` out 1 each: register load enables.
- `PCout, HIout, LOout, ZHighout, ZLowout, MDRout, Cout` out 1 each: bus drives.
- `Read, IncPC` out 1 each: memory read, PC increment.
- `OP` out 5: ALU operation.
- `Running` out 1: high in every state except IDLE and HALT.
- `Halted` out 1: high in HALT.
- `IllegalOp` out 1: one-cycle pulse on an unsupported opcode.

## Operation
- Moore FSM. All outputs decode from the state register and `IR` only.
- Every output not listed for a state is 0.
- At most one bus driver is active in any state.
- IDLE: all outputs 0. Moves to T0 on `Start`.
- Fetch:
  - T0: `PCout MARin IncPC`.
  - T1: `PCin Read MDRin`.
  - T2: `MDRout IRin`.
- T3 dispatches on op. The IR loaded at the end of T2 is valid in T3.
- R-type, opcodes add 00011 through rol 01011:
  - T3: `Rout[Rb] Yin`.
  - T4: `Rout[Rc] ZLowin`, `OP`=mapped ALU op.
  - T5: `ZLowout Rin[Ra]`.
  - Then T0.
- Immediate, opcodes addi 01100 / andi 01101 / ori 01110:
  - T3: `Rout[Rb] Yin`.
  - T4: `Cout ZLowin`, `OP`.
  - T5: `ZLowout Rin[Ra]`.
  - Then T0.
- mul 01111 / div 10000:
  - T3: `Rout[Ra] Yin`.
  - T4: `Rout[Rb] ZHighin ZLowin`, `OP` (ALU_MUL=5'b00110).
  - T5: `ZLowout LOin`.
  - T6: `ZHighout HIin`.
  - Then T0.
- neg 10001 / not 10010:
  - T3: `Rout[Rb] ZLowin`, `OP`.
  - T4: `ZLowout Rin[Ra]`.
  - Then T0.
- nop 11010: T3 with all outputs 0, then T0.
- halt 11011: T3 with all outputs 0, then HALT. HALT holds until `Clear`; `Start` is ignored.
- Any other opcode, including ld, st and branches (not yet supported): `IllegalOp`=1 in T3, no enables, then T0.
- `OP` is 0 in every state that does not assert `ZLowin`.

## Timing
- Each state lasts exactly one clock. Datapath registers capture on the rising edge that ends the state.
- Reset: `Clear` high at an edge puts the FSM in IDLE. From the next cycle, all outputs are 0, including `Running`, `Halted` and `IllegalOp`.
- `Clear` overrides `Start` and all transitions. `Clear` mid-instruction aborts it: later-state enables never assert.
- Cycles per instruction, from T0 to the next T0:
  - nop/halt/illegal: 4.
  - neg/not: 5.
  - R-type/immediate: 6.
  - mul/div: 7.
- `Start` sampled high in IDLE gives T0 on the next cycle.
- Ra=Rb or Ra=Rc is legal. Register read and write happen in different states, so there is no hazard.
- Register fields are 4 bits, so no out-of-range index exists. R0 is a normal register.

## Structure
- `cpu_ctrl_pkg` holds:
  - opcode localparams (5-bit);
  - ALU op localparams, including ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SHR, ALU_SHL, ALU_ROR, ALU_ROL, ALU_MUL=5'b00110, ALU_DIV, ALU_NEG, ALU_NOT;
  - the opcode-to-ALU-op mapping function;
  - the state encoding: IDLE, T0–T6, HALT.
- One sub-module, `reg_select_decoder`: 4-bit field plus enable in, 16-bit one-hot out. Instantiated twice, for `Rin` and `Rout`.

## Test plan
- Reset/idle: `Clear` high for 2 cycles, then low with `Start`=0 for 5 cycles. Every output must stay 0 throughout.
- MUL, `IR`=0x7B380000 (mul R6,R7):
  - T3: `Rout`=0x0040, `Yin`=1.
  - T4: `Rout`=0x0080, `OP`=00110, `ZHighin`=`ZLowin`=1.
  - T5: `ZLowout LOin`.
  - T6: `ZHighout HIin`.
  - Next cycle is T0.
- ADD R1,R2,R3, `IR`=0x18918000:
  - T3: `Rout`=0x0004, `Yin`.
  - T4: `Rout`=0x0008, `ZLowin`, `OP`=ALU_ADD.
  - T5: `ZLowout`, `Rin`=0x0002.
  - 6-cycle period.
- ADDI R4,R5,5, `IR`=0x62280005:
  - T3: `Rout`=0x0020.
  - T4: `Cout`=1, `Rout`=0.
  - T5: `Rin`=0x0010.
- Opcode handling:
  - `IR`=0x00000000 (ld): `IllegalOp`=1 in T3 only, no enables, then T0.
  - `IR`=0xD8000000 (halt): `Halted`=1, `Running`=0, outputs frozen at 0 while `Start` pulses; `Clear` returns to IDLE.
- Abort: `Clear` high during T4 of mul. Next cycle is IDLE with all outputs 0; `LOin`/`HIin` never assert.
